// File: rtl/conv1d_engine_pkg.sv
// Shared constants, FSM state type and result saturation for the conv1d compute stage.
package conv1d_engine_pkg;

    localparam int unsigned MaxTaps     = 8;
    localparam int unsigned AddrWidth   = 7;
    localparam int unsigned WeightWidth = 8;
    localparam int unsigned DataWidth   = 32;
    // 32x8 signed products need 40 bits; eight of them summed need 3 more.
    localparam int unsigned AccWidth    = 43;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        DONE
    } state_t;

    // Clamp the exact accumulator to the signed 32-bit range.
    function automatic logic [DataWidth-1:0] saturate(input logic signed [AccWidth-1:0] v);
        logic [AccWidth-DataWidth:0] hi;
        hi = v[AccWidth-1:DataWidth-1];
        if (hi == '0 || hi == '1) begin
            return v[DataWidth-1:0];
        end else if (v[AccWidth-1]) begin
            return {1'b1, {(DataWidth-1){1'b0}}};
        end else begin
            return {1'b0, {(DataWidth-1){1'b1}}};
        end
    endfunction

endpackage

// File: rtl/conv1d_sram_pkg.sv
// Request/response types for the conv1d accelerator's shared 128-word SRAM port.
package conv1d_sram_pkg;

    localparam int unsigned SramAddrWidth = 7;
    localparam int unsigned SramDataWidth = 32;

    typedef struct packed {
        logic                     req;
        logic                     we;
        logic [SramAddrWidth-1:0] addr;
        logic [SramDataWidth-1:0] wdata;
        logic [3:0]               be;
    } sram_req_t;

    typedef struct packed {
        logic [SramDataWidth-1:0] rdata;
        logic                     valid;
    } sram_rsp_t;

endpackage

// File: rtl/conv1d_engine_if.sv
// SRAM port bundle between the conv1d engine (master) and the shared SRAM (slave).
interface conv1d_engine_if;
    import conv1d_sram_pkg::*;

    sram_req_t mem_req_o;
    sram_rsp_t mem_rsp_i;

    modport master (output mem_req_o, input mem_rsp_i);
    modport slave  (input mem_req_o, output mem_rsp_i);
endinterface

// File: rtl/conv1d_mac_tree.sv
// Combinational multiply-accumulate over the sample window; taps at or beyond K add nothing.
module conv1d_mac_tree
    import conv1d_engine_pkg::*;
#(
    parameter int unsigned MAX_TAPS     = MaxTaps,
    parameter int unsigned WEIGHT_WIDTH = WeightWidth
) (
    input  logic [MAX_TAPS-1:0][DataWidth-1:0] window_i,
    input  logic [MAX_TAPS*WEIGHT_WIDTH-1:0]   weights_i,
    input  logic [3:0]                         ksize_i,
    output logic [DataWidth-1:0]               result_o
);

    logic signed [AccWidth-1:0] acc;

    // Exact signed sum of the active tap products.
    always_comb begin
        acc = '0;
        for (int unsigned k = 0; k < MAX_TAPS; k++) begin
            if (k < 32'(ksize_i)) begin
                acc = acc + AccWidth'($signed(weights_i[k*WEIGHT_WIDTH +: WEIGHT_WIDTH]))
                          * AccWidth'($signed(window_i[k]));
            end
        end
    end

    assign result_o = saturate(acc);

endmodule

// File: rtl/conv1d_engine.sv
// conv1d compute stage: streams samples from SRAM through a sliding window and writes
// saturated valid-mode convolution results back to SRAM.
module conv1d_engine
    import conv1d_engine_pkg::*;
    import conv1d_sram_pkg::*;
#(
    parameter int unsigned MAX_TAPS     = MaxTaps,
    parameter int unsigned ADDR_WIDTH   = AddrWidth,
    parameter int unsigned WEIGHT_WIDTH = WeightWidth
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           start_i,
    input  logic [ADDR_WIDTH:0]            len_i,
    input  logic [3:0]                     ksize_i,
    input  logic [MAX_TAPS*WEIGHT_WIDTH-1:0] weights_i,
    input  logic [ADDR_WIDTH-1:0]          out_base_i,
    conv1d_engine_if.master                mem,
    output logic                           mem_own_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_o
);

    localparam logic [ADDR_WIDTH+1:0] Depth = (ADDR_WIDTH+2)'(2**ADDR_WIDTH);

    state_t state_q, state_d;

    logic [ADDR_WIDTH:0]                  n_q, rd_ptr_q, captured;
    logic [3:0]                           k_q;
    logic [MAX_TAPS*WEIGHT_WIDTH-1:0]     w_q;
    logic [ADDR_WIDTH-1:0]                base_q, wr_ptr_q;
    logic                                 err_q;
    logic [MAX_TAPS-1:0][DataWidth-1:0]   win_q;
    logic [DataWidth-1:0]                 y;
    sram_req_t                            req;

    logic [ADDR_WIDTH+1:0] n_ext, k_ext, base_ext, end_addr;
    logic                  cfg_legal;

    // Read data is consumed on the fixed cycle after the read, so valid is not needed.
    logic unused_rsp_valid;
    assign unused_rsp_valid = mem.mem_rsp_i.valid;

    assign n_ext    = (ADDR_WIDTH+2)'(len_i);
    assign k_ext    = (ADDR_WIDTH+2)'(ksize_i);
    assign base_ext = (ADDR_WIDTH+2)'(out_base_i);
    assign end_addr = base_ext + n_ext - k_ext + (ADDR_WIDTH+2)'(1);

    // A zero-length input is rejected by K<=N since K must be at least 1.
    assign cfg_legal = (k_ext != '0)
                    && (k_ext <= (ADDR_WIDTH+2)'(MAX_TAPS))
                    && (k_ext <= n_ext)
                    && (n_ext <= Depth)
                    && !((base_ext != '0) && (base_ext < n_ext))
                    && (end_addr <= Depth);

    assign captured = rd_ptr_q + (ADDR_WIDTH+1)'(1);

    conv1d_mac_tree #(
        .MAX_TAPS     (MAX_TAPS),
        .WEIGHT_WIDTH (WEIGHT_WIDTH)
    ) u_mac (
        .window_i  (win_q),
        .weights_i (w_q),
        .ksize_i   (k_q),
        .result_o  (y)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and SRAM request decode.
    always_comb begin
        state_d = state_q;
        req     = '0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = cfg_legal ? RD : DONE;
                end
            end
            RD: begin
                req.req  = 1'b1;
                req.addr = rd_ptr_q[ADDR_WIDTH-1:0];
                state_d  = CAP;
            end
            CAP: begin
                state_d = (captured >= (ADDR_WIDTH+1)'(k_q)) ? WR : RD;
            end
            WR: begin
                req.req   = 1'b1;
                req.we    = 1'b1;
                req.be    = 4'hF;
                req.addr  = base_q + wr_ptr_q;
                req.wdata = y;
                state_d   = (rd_ptr_q == n_q) ? DONE : RD;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Configuration latch, pointers and sliding window (newest sample at tap K-1).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            n_q      <= '0;
            k_q      <= '0;
            w_q      <= '0;
            base_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            err_q    <= 1'b0;
            win_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        err_q    <= !cfg_legal;
                        n_q      <= len_i;
                        k_q      <= ksize_i;
                        w_q      <= weights_i;
                        base_q   <= out_base_i;
                        rd_ptr_q <= '0;
                        wr_ptr_q <= '0;
                        win_q    <= '0;
                    end
                end
                CAP: begin
                    for (int unsigned i = 0; i < MAX_TAPS - 1; i++) begin
                        if (i + 1 < 32'(k_q)) begin
                            win_q[i] <= win_q[i+1];
                        end else if (i + 1 == 32'(k_q)) begin
                            win_q[i] <= mem.mem_rsp_i.rdata;
                        end
                    end
                    if (32'(k_q) == MAX_TAPS) begin
                        win_q[MAX_TAPS-1] <= mem.mem_rsp_i.rdata;
                    end
                    rd_ptr_q <= captured;
                end
                WR: begin
                    wr_ptr_q <= wr_ptr_q + (ADDR_WIDTH)'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign mem.mem_req_o = req;
    assign busy_o        = (state_q == RD) || (state_q == CAP) || (state_q == WR);
    assign mem_own_o     = busy_o;
    assign done_o        = (state_q == DONE);
    assign err_o         = err_q;

endmodule

// File: tb/tb_conv1d_engine.sv
// Self-checking bench for conv1d_engine: SRAM model, scoreboard of expected writes,
// and a plain-arithmetic convolution reference.
module tb_conv1d_engine;
    import conv1d_sram_pkg::*;

    typedef struct packed {
        logic [6:0]  addr;
        logic [31:0] data;
    } exp_t;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -SMAX - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic [3:0]  ksize = '0;
    logic [63:0] weights = '0;
    logic [6:0]  base = '0;
    logic        own, busy, done, err;

    int checks = 0;
    int errors = 0;

    exp_t        sb_q[$];
    logic [31:0] sram    [128];
    logic [31:0] exp_mem [128];
    logic [31:0] x_img   [128];
    logic [31:0] ld_buf  [128];

    logic        bd_we = 1'b0;
    logic [6:0]  bd_addr = '0;
    logic [31:0] bd_data = '0;

    conv1d_engine_if bus();

    conv1d_engine #(
        .MAX_TAPS     (8),
        .ADDR_WIDTH   (7),
        .WEIGHT_WIDTH (8)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .len_i      (len),
        .ksize_i    (ksize),
        .weights_i  (weights),
        .out_base_i (base),
        .mem        (bus),
        .mem_own_o  (own),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err)
    );

    always #5 clk = ~clk;

    // SRAM model with one-cycle read latency and a backdoor write port for preloading.
    always @(posedge clk) begin
        bus.mem_rsp_i.valid <= 1'b0;
        if (bd_we) begin
            sram[bd_addr] <= bd_data;
        end else if (bus.mem_req_o.req) begin
            if (bus.mem_req_o.we) begin
                sram[bus.mem_req_o.addr] <= bus.mem_req_o.wdata;
            end else begin
                bus.mem_rsp_i.rdata <= sram[bus.mem_req_o.addr];
                bus.mem_rsp_i.valid <= 1'b1;
            end
        end
    end

    // Scoreboard monitor: every SRAM write must match the next expected result.
    always @(negedge clk) begin
        if (rst_n && bus.mem_req_o.req && bus.mem_req_o.we) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_write unexpected actual addr=%0d data=%h required none",
                         bus.mem_req_o.addr, bus.mem_req_o.wdata);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (bus.mem_req_o.addr !== e.addr || bus.mem_req_o.wdata !== e.data ||
                    bus.mem_req_o.be !== 4'hF) begin
                    errors++;
                    $display("FAIL sb_write actual addr=%0d data=%h be=%h required addr=%0d data=%h be=f",
                             bus.mem_req_o.addr, bus.mem_req_o.wdata, bus.mem_req_o.be, e.addr, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit is_legal(input int n, input int k, input int b);
        if (n < 1 || n > 128) return 1'b0;
        if (k < 1 || k > 8 || k > n) return 1'b0;
        if (b != 0 && b < n) return 1'b0;
        if (b + (n - k + 1) > 128) return 1'b0;
        return 1'b1;
    endfunction

    // y[i] = sum over k of w[k] * x[i+k], clamped to signed 32 bits.
    function automatic logic [31:0] ref_y(input int i, input int k, input logic [63:0] w);
        longint s = 0;
        for (int j = 0; j < k; j++) begin
            s += longint'($signed(w[j*8 +: 8])) * longint'($signed(x_img[i+j]));
        end
        if (s > SMAX) return 32'h7FFF_FFFF;
        if (s < SMIN) return 32'h8000_0000;
        return s[31:0];
    endfunction

    task automatic bd_write(input int a, input logic [31:0] d);
        bd_we   = 1'b1;
        bd_addr = 7'(a);
        bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            exp_mem[i] = ld_buf[i];
            bd_write(i, ld_buf[i]);
        end
    endtask

    task automatic mem_image(input string name);
        int bad = 0;
        int first = -1;
        for (int a = 0; a < 128; a++) begin
            if (sram[a] !== exp_mem[a]) begin
                bad++;
                if (first < 0) first = a;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s bad_words=%0d first_addr=%0d actual=%h required=%h",
                     name, bad, first, sram[first], exp_mem[first]);
        end
    endtask

    task automatic pulse_start(input int n, input int k, input logic [63:0] w, input int b);
        len     = 8'(n);
        ksize   = 4'(k);
        weights = w;
        base    = 7'(b);
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input int n, input int k, input logic [63:0] w, input int b, input int poke);
        bit legal;
        int exp_busy, busy_c, req_c, own_mm, cyc, done_cyc;
        bit done_seen, err_at_done;
        exp_t e;
        legal    = is_legal(n, k, b);
        exp_busy = legal ? 3*n - k + 1 : 0;
        x_img    = exp_mem;
        if (legal) begin
            for (int i = 0; i <= n - k; i++) begin
                e.addr = 7'(b + i);
                e.data = ref_y(i, k, w);
                sb_q.push_back(e);
                exp_mem[b + i] = e.data;
            end
        end
        pulse_start(n, k, w, b);
        busy_c = 0; req_c = 0; own_mm = 0; cyc = 0;
        done_cyc = -1; done_seen = 0; err_at_done = 0;
        while (cyc < 2000) begin
            if (own !== busy) own_mm++;
            if (busy) busy_c++;
            if (bus.mem_req_o.req) req_c++;
            if (done) begin
                done_seen   = 1'b1;
                done_cyc    = cyc;
                err_at_done = err;
                break;
            end
            if (poke != 0 && cyc == poke) begin
                start = 1'b1;
                len   = 8'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("done_seen", done_seen, 1);
        check("done_cycle", done_cyc, exp_busy);
        check("busy_cycles", busy_c, exp_busy);
        check("req_count", req_c, legal ? 2*n - k + 1 : 0);
        check("own_vs_busy_mismatches", own_mm, 0);
        check("err_at_done", err_at_done, !legal);
        @(negedge clk);
        check("done_single_pulse", done, 0);
        check("idle_after_done", busy, 0);
        check("err_sticky", err, !legal);
        check("sb_drained", sb_q.size(), 0);
        mem_image("mem_image");
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ys [8];
        logic [63:0] w;
        int wr_seen, cyc, n, k, b, kmax;

        // Clear SRAM while held in reset, then verify reset outputs.
        for (int a = 0; a < 128; a++) begin
            exp_mem[a] = '0;
            bd_write(a, '0);
        end
        check("rst_busy", busy, 0);
        check("rst_own", own, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_req", bus.mem_req_o.req, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single tap scaling into a separate output region.
        for (int i = 0; i < 4; i++) ld_buf[i] = 32'(i + 1);
        load(4);
        run(4, 1, 64'h02, 64, 0);
        check("tp1_y0", sram[64], 2);
        check("tp1_y1", sram[65], 4);
        check("tp1_y2", sram[66], 6);
        check("tp1_y3", sram[67], 8);

        // In-place three-tap moving sum.
        for (int i = 0; i < 5; i++) ld_buf[i] = 32'(i + 1);
        load(5);
        run(5, 3, 64'h01_0101, 0, 0);
        check("tp2_y0", sram[0], 6);
        check("tp2_y1", sram[1], 9);
        check("tp2_y2", sram[2], 12);
        check("tp2_x3_kept", sram[3], 4);
        check("tp2_x4_kept", sram[4], 5);

        // Saturation at both rails and a small negative result.
        ld_buf[0] = 32'h7FFF_FFFF;
        ld_buf[1] = 32'h7FFF_FFFF;
        load(2);
        run(2, 2, 64'h7F7F, 8, 0);
        check("sat_pos", sram[8], 32'h7FFF_FFFF);
        run(2, 2, 64'h8080, 8, 0);
        check("sat_neg", sram[8], 32'h8000_0000);
        ld_buf[0] = 32'd5;
        ld_buf[1] = 32'd7;
        load(2);
        run(2, 2, 64'hFF01, 8, 0);
        check("mixed_sign", sram[8], 32'hFFFF_FFFE);

        // Illegal configurations, then a legal start clears the error.
        run(4, 0, 64'h01, 64, 0);
        run(5, 6, 64'h01, 64, 0);
        run(5, 1, 64'h01, 2, 0);
        run(128, 1, 64'h01, 64, 0);
        run(10, 9, 64'h01, 64, 0);
        run(4, 1, 64'h03, 64, 0);

        // Reset asserted while the third result is being written.
        for (int i = 0; i < 8; i++) ld_buf[i] = $urandom_range(0, 1000) - 500;
        load(8);
        w = {48'h0, 8'($urandom), 8'($urandom)};
        x_img = exp_mem;
        for (int i = 0; i < 7; i++) begin
            exp_t e;
            ys[i]  = ref_y(i, 2, w);
            e.addr = 7'(64 + i);
            e.data = ys[i];
            sb_q.push_back(e);
        end
        pulse_start(8, 2, w, 64);
        wr_seen = 0;
        cyc = 0;
        while (cyc < 500) begin
            if (bus.mem_req_o.req && bus.mem_req_o.we) begin
                wr_seen++;
                if (wr_seen == 3) break;
            end
            @(negedge clk);
            cyc++;
        end
        check("reached_third_wr", wr_seen, 3);
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_own", own, 0);
        check("arst_done", done, 0);
        check("arst_err", err, 0);
        check("arst_req", bus.mem_req_o.req, 0);
        @(negedge clk);
        @(negedge clk);
        sb_q.delete();
        exp_mem[64] = ys[0];
        exp_mem[65] = ys[1];
        mem_image("mem_after_reset");
        rst_n = 1'b1;
        @(negedge clk);
        run(8, 2, w, 64, 0);

        // Start pulsed mid-run with a different length must be ignored.
        for (int i = 0; i < 6; i++) ld_buf[i] = $urandom;
        load(6);
        run(6, 2, {48'h0, 8'($urandom), 8'($urandom)}, 20, 3);

        // Randomized legal configurations.
        for (int it = 0; it < 8; it++) begin
            n    = $urandom_range(1, 24);
            kmax = (n < 8) ? n : 8;
            k    = $urandom_range(1, kmax);
            b    = $urandom_range(0, 1) ? 0 : $urandom_range(n, 128 - (n - k + 1));
            for (int i = 0; i < n; i++) begin
                ld_buf[i] = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 2000)) - 32'd1000;
            end
            load(n);
            run(n, k, {$urandom, $urandom}, b, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
